// File: rtl/pmem_responder_if.sv
// Line-granular physical-memory bus between a cache/arbiter initiator and the memory endpoint.
// Initiator holds pmem_read/pmem_write with address and write data until pmem_resp pulses.
// pmem_rdata is meaningful only in the cycle pmem_resp is high for a read.
interface pmem_responder_if;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output pmem_address,
        output pmem_read,
        output pmem_write,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp
    );

    modport slave (
        input  pmem_address,
        input  pmem_read,
        input  pmem_write,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp
    );
endinterface

// File: rtl/pmem_responder.sv
// Purpose: 256-bit line memory endpoint for the pmem_* bus; one read or write in flight at a time.
// Latency: pmem_resp high in the cycle after edge E0+LATENCY for a request accepted at E0.
// Backpressure: none beyond the held-request protocol; new requests are taken only in IDLE
//               (minimum spacing LATENCY+3 cycles); requests during BUSY/RESP/DONE are ignored.
//
// Ports: clk, rst_n (async active-low), pmem (slave modport of pmem_responder_if):
//   pmem_address[31:0] byte address (bits [4:0] ignored, line index = bits [5+IDX_BITS-1:5]),
//   pmem_read / pmem_write held until pmem_resp, pmem_wdata[255:0],
//   pmem_rdata[255:0] (holds its last value outside a read response), pmem_resp one-cycle pulse.
// Optional build macro PMEM_RESP_STALL_EN: adds 0..7 pseudo-random extra cycles of latency
// per request from an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5).
module pmem_responder #(
    parameter int IDX_BITS = 8,
    parameter int LATENCY  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pmem_responder_if.slave   pmem
);

    // Wide enough for LATENCY-1 (max 254) plus up to 7 stall cycles.
    localparam int                CNT_W     = 9;
    localparam int                DEPTH     = 1 << IDX_BITS;
    localparam logic [CNT_W-1:0]  LOAD_BASE = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
            $error("pmem_responder: LATENCY must be in 1..255");
        end
        if (IDX_BITS < 1 || IDX_BITS > 27) begin : g_bad_idx
            $error("pmem_responder: IDX_BITS must be in 1..27");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_load;
    logic [IDX_BITS-1:0]   idx_q;
    logic [255:0]          wdata_q;
    logic                  op_wr_q;
    logic [255:0]          rdata_q;
    logic                  accept;
    logic                  commit;

    // Line storage; deliberately outside the reset domain so contents survive rst_n.
    logic [255:0]          mem [0:DEPTH-1];

    // Only the index field of the address is used; the rest aliases.
    logic                  unused_addr_bits;
    assign unused_addr_bits = &{1'b0, pmem.pmem_address};

`ifdef PMEM_RESP_STALL_EN
    logic [7:0]            lfsr;
    logic                  lfsr_fb;

    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    // Extra delay uses the LFSR value current at acceptance, before it advances.
    assign cnt_load = LOAD_BASE + {{(CNT_W-3){1'b0}}, lfsr[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    assign cnt_load = LOAD_BASE;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (pmem.pmem_read || pmem.pmem_write) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // The edge that sees the counter at zero is the commit edge.
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = DONE;
            end
            DONE: begin
                // Recovery cycle: the initiator is still dropping its request.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, latency counter and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                idx_q   <= pmem.pmem_address[5 +: IDX_BITS];
                wdata_q <= pmem.pmem_wdata;
                // Read and write together resolve to a write.
                op_wr_q <= pmem.pmem_write;
                cnt     <= cnt_load;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (commit && !op_wr_q) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // Array write port: no reset, so a write that reached its commit edge persists.
    always_ff @(posedge clk) begin
        if (commit && op_wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Decoded straight from state so an asynchronous reset drops it immediately.
    assign pmem.pmem_resp  = (state == RESP);
    assign pmem.pmem_rdata = rdata_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    property p_resp_single_cycle;
        @(posedge clk) disable iff (!rst_n) pmem.pmem_resp |=> !pmem.pmem_resp;
    endproperty
    a_resp_single_cycle: assert property (p_resp_single_cycle);

    property p_resp_from_busy;
        @(posedge clk) disable iff (!rst_n) (state_nxt == RESP) |-> (state == BUSY);
    endproperty
    a_resp_from_busy: assert property (p_resp_from_busy);

endmodule
